// File: rtl/present_rx_pipe.sv
// present_rx_pipe: PRESENT receive stage. Takes one Hamming-protected
// ciphertext frame per rx_valid/rx_ready handshake, corrects each 16-bit
// lane, decrypts the 64-bit result and queues {plaintext, error} in a FIFO.
// Optional feature macro: PRESENT_RX_SECDED_EN (22-bit lanes with overall
// parity, double-error detection). Undefined: 21-bit SEC lanes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rx_valid/rx_ready   frame handshake; rx_data = 4 lanes of CW_W bits
//   key                 80-bit decryption key, sampled on accept
//   msg_valid/msg_ready FIFO head handshake; msg, msg_err = head payload
//   corr_cnt            corrected lanes since reset (saturating)
//   frame_cnt           accepted frames since reset (wrapping)
//   busy                frame in flight

// Iterative PRESENT-80 decryptor: 31 forward key-schedule steps to reach the
// last round key, then 31 inverse rounds. rst loads ct/key; finish holds
// high until the next rst.
module present_decrypt (
   input  logic        clk,
   input  logic        rst,
   input  logic [79:0] key,
   input  logic [63:0] ct,
   output logic [63:0] pt,
   output logic        finish
);
   localparam logic [63:0] SBOX = 64'h2174_8FE3_DA09_B65C;
   localparam logic [63:0] SINV = 64'hA970_364B_D21C_8FE5;

   logic [63:0] st, p_inv, st_inv;
   logic [79:0] kr, k_fwd, k_bwd, k_rot, k_tmp;
   logic [4:0]  rc;
   logic        dec, fin;

   // Forward and inverse key update for round counter rc
   always_comb begin
      k_rot        = {kr[18:0], kr[79:19]};
      k_fwd        = k_rot;
      k_fwd[79:76] = SBOX[{k_rot[79:76], 2'b00} +: 4];
      k_fwd[19:15] = k_rot[19:15] ^ rc;
      k_tmp        = kr;
      k_tmp[19:15] = kr[19:15] ^ rc;
      k_tmp[79:76] = SINV[{kr[79:76], 2'b00} +: 4];
      k_bwd        = {k_tmp[60:0], k_tmp[79:61]};
   end

   // Inverse pLayer (bit i <- bit 16*(i%4) + i/4) then inverse S-box layer
   always_comb begin
      p_inv  = '0;
      st_inv = '0;
      for (int i = 0; i < 64; i++) p_inv[i] = st[16*(i%4) + i/4];
      for (int n = 0; n < 16; n++)
         st_inv[4*n +: 4] = SINV[{p_inv[4*n +: 4], 2'b00} +: 4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st  <= ct;
         kr  <= key;
         rc  <= 5'd1;
         dec <= 1'b0;
         fin <= 1'b0;
      end else if (!fin) begin
         if (!dec) begin
            kr <= k_fwd;
            if (rc == 5'd31) begin
               dec <= 1'b1;
               st  <= st ^ k_fwd[79:16];
            end else begin
               rc <= rc + 5'd1;
            end
         end else begin
            kr <= k_bwd;
            st <= st_inv ^ k_bwd[79:16];
            if (rc == 5'd1) fin <= 1'b1;
            else            rc  <= rc - 5'd1;
         end
      end
   end

   assign pt     = st;
   assign finish = fin;
endmodule

module present_rx_pipe #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 16
`ifdef PRESENT_RX_SECDED_EN
   , localparam int unsigned CW_W = 22
`else
   , localparam int unsigned CW_W = 21
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rx_valid,
   output logic              rx_ready,
   input  logic [4*CW_W-1:0] rx_data,
   input  logic [79:0]       key,
   output logic              msg_valid,
   input  logic              msg_ready,
   output logic [63:0]       msg,
   output logic              msg_err,
   output logic [CNT_W-1:0]  corr_cnt,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              busy
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_FW = PTR_W + 1;
   localparam int unsigned SUM_W = CNT_W + 3;

   typedef enum logic [2:0] {IDLE, DECODE, START, RUN, PUSH} state_t;
   state_t state, state_n;

   logic [4*CW_W-1:0] data_q;
   logic [79:0]       key_q;
   logic [63:0]       ct_q, ct_dec, dec_pt;
   logic              unc_q, unc_any, dec_finish, dec_rst;
   logic [2:0]        corr_n;
   logic [17:0]       lane_r;
   logic [SUM_W-1:0]  corr_sum;
   logic [CNT_W-1:0]  corr_sat, corr_cnt_q, frame_cnt_q;
   logic              accept, load_ct, push, pop, rx_ready_q;
   logic [64:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_FW-1:0] count, count_n;

   // Lane decoder: returns {uncorrectable, corrected, data[15:0]}
   function automatic logic [17:0] lane_dec(input logic [CW_W-1:0] cw);
      logic [4:0]  s;
      logic [20:0] c;
      logic        corr, unc;
      s    = '0;
      c    = cw[20:0];
      corr = 1'b0;
      unc  = 1'b0;
      for (int p = 1; p <= 21; p++) if (cw[p-1]) s = s ^ 5'(p);
`ifdef PRESENT_RX_SECDED_EN
      // P bad with s=0 means only the overall parity bit flipped
      if (s == 5'd0) begin
         corr = ^cw;
      end else if (s > 5'd21 || !(^cw)) begin
         unc = 1'b1;
      end else begin
         c[s - 5'd1] = ~c[s - 5'd1];
         corr        = 1'b1;
      end
`else
      if (s > 5'd21) begin
         unc = 1'b1;
      end else if (s != 5'd0) begin
         c[s - 5'd1] = ~c[s - 5'd1];
         corr        = 1'b1;
      end
`endif
      // Data occupies the non-power-of-two positions in ascending order
      return {unc, corr, c[20:16], c[14:8], c[6:4], c[2]};
   endfunction

   // Four-lane correction of the registered frame
   always_comb begin
      ct_dec  = '0;
      corr_n  = '0;
      unc_any = 1'b0;
      lane_r  = '0;
      for (int k = 0; k < 4; k++) begin
         lane_r             = lane_dec(data_q[CW_W*k +: CW_W]);
         ct_dec[16*k +: 16] = lane_r[15:0];
         corr_n             = corr_n + 3'(lane_r[16]);
         unc_any            = unc_any | lane_r[17];
      end
      corr_sum = SUM_W'(corr_cnt_q) + SUM_W'(corr_n);
      corr_sat = (corr_sum[SUM_W-1:CNT_W] != '0) ? '1 : corr_sum[CNT_W-1:0];
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // FSM next state
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (rx_valid && rx_ready_q) state_n = DECODE;
         DECODE:  state_n = unc_any ? PUSH : START;
         START:   state_n = RUN;
         RUN:     if (dec_finish) state_n = PUSH;
         PUSH:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // FSM control outputs
   always_comb begin
      accept  = 1'b0;
      load_ct = 1'b0;
      push    = 1'b0;
      case (state)
         IDLE:    accept  = rx_valid & rx_ready_q;
         DECODE:  load_ct = 1'b1;
         PUSH:    push    = 1'b1;
         default: ;
      endcase
   end

   assign dec_rst = rst | (state == START);
   assign pop     = msg_ready & (count != '0);
   assign count_n = count + CNT_FW'(push) - CNT_FW'(pop);

   present_decrypt u_dec (
      .clk    (clk),
      .rst    (dec_rst),
      .key    (key_q),
      .ct     (ct_q),
      .pt     (dec_pt),
      .finish (dec_finish)
   );

   // Frame capture, counters and FIFO pointers
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q      <= '0;
         key_q       <= '0;
         ct_q        <= '0;
         unc_q       <= 1'b0;
         corr_cnt_q  <= '0;
         frame_cnt_q <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         rx_ready_q  <= 1'b0;
      end else begin
         if (accept) begin
            data_q      <= rx_data;
            key_q       <= key;
            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         end
         if (load_ct) begin
            ct_q       <= ct_dec;
            unc_q      <= unc_any;
            corr_cnt_q <= corr_sat;
         end
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count      <= count_n;
         rx_ready_q <= (state_n == IDLE) && (count_n < CNT_FW'(FIFO_DEPTH));
      end
   end

   // FIFO storage; uncorrectable frames carry zero plaintext
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= {unc_q, unc_q ? 64'd0 : dec_pt};
   end

   assign rx_ready  = rx_ready_q;
   assign msg_valid = (count != '0);
   assign msg       = msg_valid ? fifo_mem[rd_ptr][63:0] : 64'd0;
   assign msg_err   = msg_valid & fifo_mem[rd_ptr][64];
   assign corr_cnt  = corr_cnt_q;
   assign frame_cnt = frame_cnt_q;
   assign busy      = (state != IDLE);
endmodule

// File: tb/tb_present_rx_pipe.sv
// tb_present_rx_pipe: randomized frames against a behavioural model
// (forward PRESENT encryption, Hamming encode/decode by position rules).
// A second instance with CNT_W=2 shares the stimulus for counter limits.
`timescale 1ns/1ps
module tb_present_rx_pipe;
`ifdef PRESENT_RX_SECDED_EN
   localparam int unsigned CW_W = 22;
`else
   localparam int unsigned CW_W = 21;
`endif
   localparam int unsigned DEPTH = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_valid = 1'b0;
   logic [4*CW_W-1:0] rx_data = '0;
   logic [79:0]       key = '0;
   logic              msg_ready = 1'b0;
   logic              rx_ready, msg_valid, msg_err, busy;
   logic [63:0]       msg;
   logic [15:0]       corr_cnt, frame_cnt;
   logic              rx_ready2, msg_valid2, msg_err2, busy2;
   logic [63:0]       msg2;
   logic [1:0]        corr_cnt2, frame_cnt2;

   int tests = 0;
   int fails = 0;
   logic [64:0] exp_q[$];
   longint corr_model = 0;
   longint frame_model = 0;
   bit rand_on;

   always #5 clk = ~clk;

   present_rx_pipe #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_data(rx_data), .key(key), .msg_valid(msg_valid),
      .msg_ready(msg_ready), .msg(msg), .msg_err(msg_err),
      .corr_cnt(corr_cnt), .frame_cnt(frame_cnt), .busy(busy));

   present_rx_pipe #(.FIFO_DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_ready(rx_ready2),
      .rx_data(rx_data), .key(key), .msg_valid(msg_valid2),
      .msg_ready(msg_ready), .msg(msg2), .msg_err(msg_err2),
      .corr_cnt(corr_cnt2), .frame_cnt(frame_cnt2), .busy(busy2));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [3:0] sbox(input logic [3:0] x);
      logic [3:0] tab [16];
      tab = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
              4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
      return tab[x];
   endfunction

   // Reference PRESENT-80 encryption
   function automatic logic [63:0] present_enc(input logic [63:0] pt, input logic [79:0] k_in);
      logic [63:0] s, t;
      logic [79:0] k;
      s = pt;
      k = k_in;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ k[79:16];
         for (int n = 0; n < 16; n++) s[n*4 +: 4] = sbox(s[n*4 +: 4]);
         t = '0;
         for (int i = 0; i < 63; i++) t[(i*16) % 63] = s[i];
         t[63] = s[63];
         s = t;
         k = {k[18:0], k[79:19]};
         k[79:76] = sbox(k[79:76]);
         k[19:15] = k[19:15] ^ 5'(r);
      end
      return s ^ k[79:16];
   endfunction

   function automatic bit is_pow2(input int p);
      return (p & (p - 1)) == 0;
   endfunction

   // Encode 16 data bits: parity bits make the position-XOR syndrome zero
   function automatic logic [CW_W-1:0] lane_enc(input logic [15:0] d);
      logic [CW_W-1:0] cw;
      int j, syn;
      cw = '0;
      j = 0;
      for (int p = 1; p <= 21; p++)
         if (!is_pow2(p)) begin
            cw[p-1] = d[j];
            j++;
         end
      syn = 0;
      for (int p = 1; p <= 21; p++) if (cw[p-1]) syn = syn ^ p;
      for (int b = 0; b < 5; b++) cw[(1 << b) - 1] = syn[b];
`ifdef PRESENT_RX_SECDED_EN
      cw[21] = ^cw[20:0];
`endif
      return cw;
   endfunction

   task automatic lane_model(input logic [CW_W-1:0] cw, output logic [15:0] d,
                             output bit corr, output bit unc);
      logic [CW_W-1:0] c;
      int s, j;
      bit pbad;
      c = cw;
      s = 0;
      corr = 0;
      unc = 0;
      for (int p = 1; p <= 21; p++) if (cw[p-1]) s = s ^ p;
`ifdef PRESENT_RX_SECDED_EN
      pbad = ^cw;
      if (s == 0) corr = pbad;
      else if (s > 21 || !pbad) unc = 1;
      else begin c[s-1] = ~c[s-1]; corr = 1; end
`else
      pbad = 0;
      if (s > 21) unc = 1;
      else if (s != 0) begin c[s-1] = ~c[s-1]; corr = 1; end
`endif
      d = '0;
      j = 0;
      for (int p = 1; p <= 21; p++)
         if (!is_pow2(p)) begin
            d[j] = c[p-1];
            j++;
         end
   endtask

   // Build, model and hand over one frame; waits for acceptance
   task automatic send_frame(input logic [63:0] pt, input logic [79:0] k,
                             input logic [4*CW_W-1:0] flips);
      logic [4*CW_W-1:0] word;
      logic [CW_W-1:0] cw;
      logic [63:0] ct, ct_rx;
      logic [15:0] d;
      bit c, u, err;
      int ncorr, n;
      ct = present_enc(pt, k);
      err = 0;
      ncorr = 0;
      ct_rx = '0;
      for (int l = 0; l < 4; l++) begin
         cw = lane_enc(ct[16*l +: 16]) ^ flips[CW_W*l +: CW_W];
         word[CW_W*l +: CW_W] = cw;
         lane_model(cw, d, c, u);
         ct_rx[16*l +: 16] = d;
         ncorr += int'(c);
         err |= u;
      end
      if (!err && ct_rx != ct) $display("note: injected errors alias to another ciphertext");
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = word;
      key      = k;
      n = 0;
      while (!rx_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (!rx_ready) begin
         check("accept_timeout", 64'(rx_ready), 64'd1);
         rx_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 rx_valid = 1'b0;
      exp_q.push_back({err, err ? 64'd0 : pt});
      corr_model  += ncorr;
      frame_model += 1;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((busy || busy2) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 64'(busy), 64'd0);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 64'(exp_q.size()), 64'd0);
      wait_idle();
   endtask

   task automatic check_counters(input string tag);
      longint c16, c2;
      c16 = (corr_model > 65535) ? 65535 : corr_model;
      c2  = (corr_model > 3) ? 3 : corr_model;
      check({tag, "_corr_cnt"},   64'(corr_cnt),   64'(c16));
      check({tag, "_frame_cnt"},  64'(frame_cnt),  64'(frame_model % 65536));
      check({tag, "_corr_cnt2"},  64'(corr_cnt2),  64'(c2));
      check({tag, "_frame_cnt2"}, 64'(frame_cnt2), 64'(frame_model % 4));
   endtask

   function automatic logic [4*CW_W-1:0] rand_mask();
      logic [4*CW_W-1:0] m;
      int r;
      int pa [3] = '{20, 19, 20};
      int pb [3] = '{2, 11, 10};
      m = '0;
      for (int l = 0; l < 4; l++) begin
         r = $urandom_range(0, 9);
         if (r >= 6 && r < 9) m[CW_W*l + $urandom_range(0, CW_W-1)] = 1'b1;
         else if (r == 9) begin
            r = $urandom_range(0, 2);
            m[CW_W*l + pa[r]] = 1'b1;
            m[CW_W*l + pb[r]] = 1'b1;
         end
      end
      return m;
   endfunction

   // Every pop is checked against the oldest expected entry
   always @(negedge clk) begin
      if (!rst && msg_valid && msg_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pop", 64'(msg_valid), 64'd0);
         end else begin
            logic [64:0] e;
            e = exp_q.pop_front();
            check("msg", msg, e[63:0]);
            check("msg_err", 64'(msg_err), 64'(e[64]));
         end
      end
   end

   initial begin
      logic [4*CW_W-1:0] m;
      // Reset behaviour
      repeat (3) @(negedge clk);
      check("rx_ready_in_reset", 64'(rx_ready), 64'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("rst_rx_ready", 64'(rx_ready), 64'd1);
      check("rst_msg_valid", 64'(msg_valid), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_msg", msg, 64'd0);
      check_counters("rst");
      check("model_vector", present_enc(64'd0, 80'd0), 64'h5579C1387B228445);

      // Known vector, clean then single and four-lane corrections
      msg_ready = 1'b1;
      send_frame(64'd0, 80'd0, '0);
      wait_drain();
      check("clean_corr", 64'(corr_cnt), 64'd0);
      check("clean_frames", 64'(frame_cnt), 64'd1);
      m = '0;
      m[CW_W*2 + 5] = 1'b1;
      send_frame(64'd0, 80'd0, m);
      wait_drain();
      check("lane2_corr", 64'(corr_cnt), 64'd1);
      m = '0;
      for (int l = 0; l < 4; l++) m[CW_W*l + 3*l + 1] = 1'b1;
      send_frame(64'd0, 80'd0, m);
      wait_drain();
      check("all_lanes_corr", 64'(corr_cnt), 64'd5);
      check("sat_corr2", 64'(corr_cnt2), 64'd3);
      check_counters("dir");

      // Uncorrectable lane: pushed at cycle 2, visible at cycle 3
      msg_ready = 1'b0;
      m = '0;
      m[20] = 1'b1;
      m[2]  = 1'b1;
      send_frame(64'h0123_4567_89AB_CDEF, 80'h1, m);
      @(negedge clk);
      check("unc_c1_valid", 64'(msg_valid), 64'd0);
      @(negedge clk);
      check("unc_c2_valid", 64'(msg_valid), 64'd0);
      check("unc_c2_busy", 64'(busy), 64'd1);
      @(negedge clk);
      check("unc_c3_valid", 64'(msg_valid), 64'd1);
      check("unc_c3_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1 msg_ready = 1'b1;
      wait_drain();
`ifdef PRESENT_RX_SECDED_EN
      m = '0;
      m[CW_W*1 + 21] = 1'b1;
      send_frame(64'd0, 80'd0, m);
      wait_drain();
`endif
      check_counters("unc");

      // Full FIFO blocks acceptance; one pop admits the next frame
      @(posedge clk);
      #1 msg_ready = 1'b0;
      for (int f = 0; f < DEPTH; f++) send_frame(64'(f) * 64'h1111, 80'(f + 7), '0);
      wait_idle();
      check("full_rx_ready", 64'(rx_ready), 64'd0);
      fork
         send_frame(64'hFEED_0000_BEEF_0005, 80'h5, '0);
         begin
            repeat (5) @(negedge clk);
            check("blocked_rx_ready", 64'(rx_ready), 64'd0);
            check("blocked_frames", 64'(frame_cnt), 64'(frame_model % 65536));
            @(posedge clk);
            #1 msg_ready = 1'b1;
            @(posedge clk);
            #1 msg_ready = 1'b0;
         end
      join
      @(posedge clk);
      #1 msg_ready = 1'b1;
      wait_drain();
      check_counters("fifo");

      // Reset during RUN discards the frame and clears everything
      send_frame(64'hA5A5_5A5A_0F0F_F0F0, 80'hABCDE, '0);
      repeat (10) @(negedge clk);
      check("run_busy", 64'(busy), 64'd1);
      @(posedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      corr_model = 0;
      frame_model = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_valid", 64'(msg_valid), 64'd0);
      check_counters("midrst");
      send_frame(64'd0, 80'd0, '0);
      wait_drain();
      check_counters("post_rst");

      // Randomized frames with random consumer back-pressure
      rand_on = 1'b1;
      fork
         begin
            for (int f = 0; f < 40; f++)
               send_frame({$urandom, $urandom}, 80'({$urandom, $urandom, $urandom}), rand_mask());
            rand_on = 1'b0;
         end
         while (rand_on) begin
            @(posedge clk);
            #1 msg_ready = ($urandom_range(0, 3) != 0);
         end
      join
      @(posedge clk);
      #1 msg_ready = 1'b1;
      wait_drain();
      check_counters("rand");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
